// File: rtl/rx_ltssm_substate_checker.sv
// Per-substate ordered-set qualification engine for the RX LTSSM over NUM_LANES masked lanes.
// Latency: start to done is at least 3 cycles (ARM, one COUNT cycle, PASS/FAIL); unsupported substates take 1 cycle.
// Backpressure: none; start is a strobe honoured only in IDLE and ignored while busy.
//
// Ports:
//   clk, reset (async, active-low)
//   start/substate/lane_mask    request from the main LTSSM
//   os_count                    per-lane OS counters, lane i at [i*CNT_W +: CNT_W]
//   tick                        1 ms timebase pulse
//   abort                       force-detect / electrical-idle abort
//   busy, clr_os_cnt            registered status / counter clear
//   done, pass, exit_to,
//   write_rate_id, write_upconfig  result, decoded from state and latched substate
module rx_ltssm_substate_checker #(
    parameter int NUM_LANES = 16,
    parameter int CNT_W     = 5,
    parameter int TMR_W     = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [3:0]                 substate,
    input  logic [NUM_LANES-1:0]       lane_mask,
    input  logic [NUM_LANES*CNT_W-1:0] os_count,
    input  logic                       tick,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [3:0]                 exit_to,
    output logic [NUM_LANES-1:0]       clr_os_cnt,
    output logic                       write_rate_id,
    output logic                       write_upconfig
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        COUNT,
        PASS,
        FAIL
    } stateT;

    localparam logic [CNT_W-1:0] REQ_8  = CNT_W'(8);
    localparam logic [CNT_W-1:0] REQ_2  = CNT_W'(2);
    localparam logic [TMR_W-1:0] TMO_2  = TMR_W'(2);
    localparam logic [TMR_W-1:0] TMO_24 = TMR_W'(24);
    localparam logic [TMR_W-1:0] TMO_48 = TMR_W'(48);

    stateT                state, stateNxt;
    logic [3:0]           latSub, latSubNxt;
    logic [NUM_LANES-1:0] latMask, latMaskNxt;
    logic [CNT_W-1:0]     reqCnt, reqCntNxt;
    logic [TMR_W-1:0]     tmoVal, tmoValNxt;
    logic [TMR_W-1:0]     timer, timerNxt;

    logic                 tblValid;
    logic [CNT_W-1:0]     tblReq;
    logic [TMR_W-1:0]     tblTmo;
    logic                 met;

    // Required count / timeout per supported substate.
    always_comb begin
        tblValid = 1'b1;
        tblReq   = '0;
        tblTmo   = '0;
        case (substate)
            4'd2:                begin tblReq = REQ_8; tblTmo = TMO_24; end
            4'd3:                begin tblReq = REQ_8; tblTmo = TMO_48; end
            4'd4, 4'd5, 4'd7:    begin tblReq = REQ_2; tblTmo = TMO_24; end
            4'd6:                begin tblReq = REQ_2; tblTmo = TMO_2;  end
            4'd8:                begin tblReq = REQ_8; tblTmo = TMO_24; end
            default:             tblValid = 1'b0;
        endcase
    end

    // Every participating lane must reach the threshold; an empty mask never qualifies.
    always_comb begin
        met = |latMask;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (latMask[i] && (os_count[i*CNT_W +: CNT_W] < reqCnt)) begin
                met = 1'b0;
            end
        end
    end

    always_comb begin
        stateNxt   = state;
        latSubNxt  = latSub;
        latMaskNxt = latMask;
        reqCntNxt  = reqCnt;
        tmoValNxt  = tmoVal;
        timerNxt   = timer;
        case (state)
            IDLE: begin
                if (start) begin
                    if (tblValid) begin
                        stateNxt   = ARM;
                        latSubNxt  = substate;
                        latMaskNxt = lane_mask;
                        reqCntNxt  = tblReq;
                        tmoValNxt  = tblTmo;
                    end else begin
                        stateNxt = FAIL;
                    end
                end
            end
            ARM: begin
                // Counters are being cleared this cycle, so their values are not examined.
                timerNxt = '0;
                stateNxt = abort ? FAIL : COUNT;
            end
            COUNT: begin
                if (tick && (timer != {TMR_W{1'b1}})) begin
                    timerNxt = timer + TMR_W'(1);
                end
                // abort beats met, met beats timeout; the timeout uses the pre-increment timer.
                if (abort) begin
                    stateNxt = FAIL;
                end else if (met) begin
                    stateNxt = PASS;
                end else if ((latMask == '0) || (timer >= tmoVal)) begin
                    stateNxt = FAIL;
                end
            end
            PASS:    stateNxt = IDLE;
            FAIL:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            latSub     <= '0;
            latMask    <= '0;
            reqCnt     <= '0;
            tmoVal     <= '0;
            timer      <= '0;
            busy       <= 1'b0;
            clr_os_cnt <= '0;
        end else begin
            state      <= stateNxt;
            latSub     <= latSubNxt;
            latMask    <= latMaskNxt;
            reqCnt     <= reqCntNxt;
            tmoVal     <= tmoValNxt;
            timer      <= timerNxt;
            busy       <= (stateNxt != IDLE);
            clr_os_cnt <= (stateNxt == ARM) ? latMaskNxt : '0;
        end
    end

    // Result outputs are pure decodes of registered state, so they only move on clk edges.
    assign done           = (state == PASS) || (state == FAIL);
    assign pass           = (state == PASS);
    assign exit_to        = (state == PASS) ? (latSub + 4'd1) : 4'd0;
    assign write_rate_id  = (state == PASS) && (latSub == 4'd3);
    assign write_upconfig = (state == PASS) && (latSub == 4'd8);

endmodule

// File: tb/tb_rx_ltssm_substate_checker.sv
// Directed bench for rx_ltssm_substate_checker with four lanes.
// Latency: checks sample 1 time unit after each rising clk edge.
// Backpressure: not applicable; stimulus is driven directly.
module tb_rx_ltssm_substate_checker;

    localparam int NL = 4;
    localparam int CW = 5;
    localparam int TW = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        substate = '0;
    logic [NL-1:0]     lane_mask = '0;
    logic [NL*CW-1:0]  os_count = '0;
    logic              tick = 1'b0;
    logic              abort = 1'b0;
    logic              busy, done, pass, write_rate_id, write_upconfig;
    logic [3:0]        exit_to;
    logic [NL-1:0]     clr_os_cnt;

    int checks = 0;
    int errors = 0;

    rx_ltssm_substate_checker #(.NUM_LANES(NL), .CNT_W(CW), .TMR_W(TW)) dut (
        .clk(clk), .reset(reset), .start(start), .substate(substate),
        .lane_mask(lane_mask), .os_count(os_count), .tick(tick), .abort(abort),
        .busy(busy), .done(done), .pass(pass), .exit_to(exit_to),
        .clr_os_cnt(clr_os_cnt), .write_rate_id(write_rate_id),
        .write_upconfig(write_upconfig)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_counts(input int c3, input int c2, input int c1, input int c0);
        logic [CW-1:0] v3, v2, v1, v0;
        v3 = CW'(c3); v2 = CW'(c2); v1 = CW'(c1); v0 = CW'(c0);
        os_count = {v3, v2, v1, v0};
    endtask

    task automatic issue(input logic [3:0] sub, input logic [NL-1:0] mask);
        substate  = sub;
        lane_mask = mask;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%0b exp=0", pass); end
        checks++; if (exit_to !== 4'd0) begin errors++; $display("FAIL reset_exit got=%0d exp=0", exit_to); end
        checks++; if (clr_os_cnt !== 4'b0000) begin errors++; $display("FAIL reset_clr got=%b exp=0000", clr_os_cnt); end
        checks++; if ({write_rate_id, write_upconfig} !== 2'b00) begin errors++; $display("FAIL reset_wr got=%b exp=00", {write_rate_id, write_upconfig}); end
        reset = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%0b exp=0", busy); end
    endtask

    // substate 2, all lanes ramp to 8 over 8 ticks.
    task automatic test_polling_active_pass();
        set_counts(0, 0, 0, 0);
        issue(4'd2, 4'b1111);
        checks++; if (clr_os_cnt !== 4'b1111) begin errors++; $display("FAIL t1_clr_arm got=%b exp=1111", clr_os_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got=%0b exp=1", busy); end
        step();
        checks++; if (clr_os_cnt !== 4'b0000) begin errors++; $display("FAIL t1_clr_count got=%b exp=0000", clr_os_cnt); end
        for (int k = 1; k <= 8; k++) begin
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_early_done k=%0d got=%0b exp=0", k, done); end
            set_counts(k, k, k, k);
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL t1_done got=%0b exp=1", done); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL t1_pass got=%0b exp=1", pass); end
        checks++; if (exit_to !== 4'd3) begin errors++; $display("FAIL t1_exit got=%0d exp=3", exit_to); end
        checks++; if ({write_rate_id, write_upconfig} !== 2'b00) begin errors++; $display("FAIL t1_wr got=%b exp=00", {write_rate_id, write_upconfig}); end
        step();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL t1_back_idle got=%b exp=00", {busy, done}); end
    endtask

    // substate 6 (2 / 2 ticks), lane 1 stuck at 1, lanes 2-3 unmasked.
    task automatic test_lanenum_wait_timeout();
        bit got;
        set_counts(0, 0, 1, 5);
        issue(4'd6, 4'b0011);
        step();
        tick = 1'b1;
        step();
        step();
        tick = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t2_early_done got=%0b exp=0", done); end
        got = 1'b0;
        for (int c = 0; c < 5 && !got; c++) begin
            step();
            got = done;
        end
        checks++; if (!got) begin errors++; $display("FAIL t2_done_wait got=timeout exp=done"); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL t2_pass got=%0b exp=0", pass); end
        checks++; if (exit_to !== 4'd0) begin errors++; $display("FAIL t2_exit got=%0d exp=0", exit_to); end
        step();
        // Same substate with masked lanes at threshold: zero unmasked lanes must not block.
        set_counts(0, 0, 2, 2);
        issue(4'd6, 4'b0011);
        step();
        step();
        checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL t2_masked_pass got=%b exp=11", {done, pass}); end
        checks++; if (exit_to !== 4'd7) begin errors++; $display("FAIL t2_masked_exit got=%0d exp=7", exit_to); end
        step();
    endtask

    // substate 3: counts reach 8 exactly when the timer reads 48.
    task automatic test_config_tie();
        set_counts(0, 7, 0, 7);
        issue(4'd3, 4'b0101);
        step();
        tick = 1'b1;
        for (int k = 0; k < 48; k++) step();
        tick = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL t3_no_early_timeout got=%0b exp=0", done); end
        set_counts(0, 8, 0, 8);
        step();
        checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL t3_tie_pass got=%b exp=11", {done, pass}); end
        checks++; if (exit_to !== 4'd4) begin errors++; $display("FAIL t3_exit got=%0d exp=4", exit_to); end
        checks++; if (write_rate_id !== 1'b1) begin errors++; $display("FAIL t3_rate_id got=%0b exp=1", write_rate_id); end
        checks++; if (write_upconfig !== 1'b0) begin errors++; $display("FAIL t3_upcfg got=%0b exp=0", write_upconfig); end
        step();
        checks++; if (write_rate_id !== 1'b0) begin errors++; $display("FAIL t3_rate_id_pulse got=%0b exp=0", write_rate_id); end
    endtask

    // substate 8 pass with a second start held during busy.
    task automatic test_back_to_back();
        set_counts(8, 8, 8, 8);
        issue(4'd8, 4'b1111);
        start = 1'b1;
        substate = 4'd2;
        step();
        step();
        start = 1'b0;
        checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL t4_pass got=%b exp=11", {done, pass}); end
        checks++; if (exit_to !== 4'd9) begin errors++; $display("FAIL t4_exit got=%0d exp=9", exit_to); end
        checks++; if ({write_upconfig, write_rate_id} !== 2'b10) begin errors++; $display("FAIL t4_wr got=%b exp=10", {write_upconfig, write_rate_id}); end
        step();
        checks++; if ({busy, done, write_upconfig} !== 3'b000) begin errors++; $display("FAIL t4_ignored_start got=%b exp=000", {busy, done, write_upconfig}); end
    endtask

    task automatic test_abort_and_fail();
        set_counts(8, 8, 8, 8);
        issue(4'd2, 4'b1111);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if ({done, pass, exit_to} !== 6'b100000) begin errors++; $display("FAIL t5_abort got=%b exp=100000", {done, pass, exit_to}); end
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL t5_abort_idle got=%b exp=00", {busy, done}); end
        issue(4'd2, 4'b0000);
        checks++; if (clr_os_cnt !== 4'b0000) begin errors++; $display("FAIL t5_mask0_clr got=%b exp=0000", clr_os_cnt); end
        step();
        step();
        checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL t5_mask0 got=%b exp=10", {done, pass}); end
        step();
        issue(4'd9, 4'b1111);
        checks++; if ({done, pass, exit_to} !== 6'b100000) begin errors++; $display("FAIL t5_unsup got=%b exp=100000", {done, pass, exit_to}); end
        checks++; if (clr_os_cnt !== 4'b0000) begin errors++; $display("FAIL t5_unsup_no_arm got=%b exp=0000", clr_os_cnt); end
        step();
    endtask

    task automatic test_async_reset();
        set_counts(0, 0, 0, 0);
        issue(4'd2, 4'b1111);
        step();
        #2 reset = 1'b0;
        #1;
        checks++; if ({busy, done, clr_os_cnt} !== 6'b000000) begin errors++; $display("FAIL t6_async got=%b exp=000000", {busy, done, clr_os_cnt}); end
        step();
        reset = 1'b1;
        step();
        set_counts(2, 2, 2, 2);
        issue(4'd4, 4'b1111);
        step();
        step();
        checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL t6_after_pass got=%b exp=11", {done, pass}); end
        checks++; if (exit_to !== 4'd5) begin errors++; $display("FAIL t6_after_exit got=%0d exp=5", exit_to); end
        step();
    endtask

    initial begin
        test_reset();
        test_polling_active_pass();
        test_lanenum_wait_timeout();
        test_config_tie();
        test_back_to_back();
        test_abort_and_fail();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
